// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I decode stage with ID/EX register, EX/MEM forwarding and load-use stall.
// Define ID_RV32M_EN to decode RV32M (funct7=0000001) ops as legal with mext_o=1.
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              id_ready,
    input  logic [31:0]       inst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [RA_W-1:0]   rf_raddr1,
    output logic [RA_W-1:0]   rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              ex_fwd_we,
    input  logic [RA_W-1:0]   ex_fwd_wd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              ex_is_load,
    input  logic              mem_fwd_we,
    input  logic [RA_W-1:0]   mem_fwd_wd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [6:0]        aluop_o,
    output logic [2:0]        alufun_o,
    output logic              alufun7_o,
    output logic [XLEN-1:0]   reg1_o,
    output logic [XLEN-1:0]   reg2_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [RA_W-1:0]   wd_o,
    output logic              wreg_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              illegal_o,
    output logic              mext_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MEXT   = 7'b0000001;

    typedef enum logic [2:0] {
        F_X, F_R, F_I, F_S, F_B, F_U, F_J
    } fmt_e;

    typedef enum logic {
        S_RUN, S_LU_STALL
    } state_e;

    state_e state_q;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [RA_W-1:0] ra1, ra2, rd;

    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];
    assign f7  = inst_i[31:25];
    assign ra1 = RA_W'(inst_i[19:15]);
    assign ra2 = RA_W'(inst_i[24:20]);
    assign rd  = RA_W'(inst_i[11:7]);

    assign rf_raddr1 = ra1;
    assign rf_raddr2 = ra2;

    logic imm_ok, r_base_ok;
    fmt_e fmt_d;
    logic mext_d;

    // Shift encodings carry funct7 in the immediate; only SRAI may use the alt value.
    assign imm_ok = (f3 == 3'd1) ? (f7 == 7'd0) :
                    (f3 == 3'd5) ? (f7 == 7'd0 || f7 == F7_ALT) : 1'b1;

    assign r_base_ok = (f7 == 7'd0) ||
                       (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5));

    // Classify the instruction format; anything unrecognised is F_X (illegal).
    always_comb begin
        fmt_d  = F_X;
        mext_d = 1'b0;
        unique case (1'b1)
            opc == OP_LUI,
            opc == OP_AUIPC:  fmt_d = F_U;
            opc == OP_JAL:    fmt_d = F_J;
            opc == OP_JALR:   fmt_d = (f3 == 3'd0) ? F_I : F_X;
            opc == OP_LOAD:   fmt_d = (f3 == 3'd3 || f3[2:1] == 2'b11) ? F_X : F_I;
            opc == OP_STORE:  fmt_d = (f3 < 3'd3) ? F_S : F_X;
            opc == OP_BRANCH: fmt_d = (f3[2:1] == 2'b01) ? F_X : F_B;
            opc == OP_IMM:    fmt_d = imm_ok ? F_I : F_X;
            opc == OP_REG: begin
`ifdef ID_RV32M_EN
                mext_d = (f7 == F7_MEXT);
`else
                mext_d = 1'b0;
`endif
                fmt_d = (r_base_ok || mext_d) ? F_R : F_X;
            end
            default: fmt_d = F_X;
        endcase
    end

    logic [31:0] imm32;

    // Assemble the sign-extended immediate for the decoded format.
    always_comb begin
        imm32 = 32'd0;
        unique case (fmt_d)
            F_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            F_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            F_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                          inst_i[30:25], inst_i[11:8], 1'b0};
            F_U: imm32 = {inst_i[31:12], 12'b0};
            F_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                          inst_i[20], inst_i[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    logic            use1_d, use2_d, wr_d, ill_d;
    logic [XLEN-1:0] src1, src2, reg1_d, reg2_d, imm_d;
    logic [RA_W-1:0] wd_d;
    logic            wreg_d, f7b_d;

    assign ill_d  = (fmt_d == F_X);
    assign use1_d = (fmt_d == F_R) || (fmt_d == F_I) ||
                    (fmt_d == F_S) || (fmt_d == F_B);
    assign use2_d = (fmt_d == F_R) || (fmt_d == F_S) || (fmt_d == F_B);
    assign wr_d   = (fmt_d == F_R) || (fmt_d == F_I) ||
                    (fmt_d == F_U) || (fmt_d == F_J);

    assign src1 = (ra1 == '0) ? '0 :
                  (ex_fwd_we && ex_fwd_wd == ra1) ? ex_fwd_data :
                  (mem_fwd_we && mem_fwd_wd == ra1) ? mem_fwd_data :
                  rf_rdata1;
    assign src2 = (ra2 == '0) ? '0 :
                  (ex_fwd_we && ex_fwd_wd == ra2) ? ex_fwd_data :
                  (mem_fwd_we && mem_fwd_wd == ra2) ? mem_fwd_data :
                  rf_rdata2;

    assign reg1_d = use1_d ? src1 : '0;
    assign reg2_d = use2_d ? src2 : '0;
    assign imm_d  = XLEN'($signed(imm32));
    assign wd_d   = wr_d ? rd : '0;
    assign wreg_d = wr_d && (rd != '0);
    assign f7b_d  = inst_i[30] && !mext_d;

    logic ex_valid_q, hazard, adv, accept;

    // A load in EX cannot forward yet; stall only if a source actually read matches.
    assign hazard = if_valid && ex_is_load && ex_fwd_we && (ex_fwd_wd != '0) &&
                    ((use1_d && ex_fwd_wd == ra1) || (use2_d && ex_fwd_wd == ra2));
    assign adv      = !ex_valid_q || ex_ready;
    assign id_ready = rst && adv && !hazard;
    assign accept   = if_valid && id_ready;

    // Load-use tracking: one stall cycle, then the held inst re-decodes with MEM fwd.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
        end else if (flush) begin
            state_q <= S_RUN;
        end else begin
            unique case (state_q)
                S_RUN:      if (hazard && adv) state_q <= S_LU_STALL;
                S_LU_STALL: state_q <= S_RUN;
                default:    state_q <= S_RUN;
            endcase
        end
    end

    logic [6:0]        aluop_q;
    logic [2:0]        alufun_q;
    logic              alufun7_q, wreg_q, illegal_q, mext_q;
    logic [XLEN-1:0]   reg1_q, reg2_q, imm_q;
    logic [RA_W-1:0]   wd_q;
    logic [ADDR_W-1:0] pc_q;

    // ID/EX register: flush kills, accept loads, EX consume without accept empties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            aluop_q    <= '0;
            alufun_q   <= '0;
            alufun7_q  <= 1'b0;
            reg1_q     <= '0;
            reg2_q     <= '0;
            imm_q      <= '0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            pc_q       <= '0;
            illegal_q  <= 1'b0;
            mext_q     <= 1'b0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            aluop_q    <= opc;
            alufun_q   <= f3;
            alufun7_q  <= f7b_d;
            reg1_q     <= reg1_d;
            reg2_q     <= reg2_d;
            imm_q      <= imm_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            pc_q       <= pc_i;
            illegal_q  <= ill_d;
            mext_q     <= mext_d;
        end else if (adv) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign aluop_o   = aluop_q;
    assign alufun_o  = alufun_q;
    assign alufun7_o = alufun7_q;
    assign reg1_o    = reg1_q;
    assign reg2_o    = reg2_q;
    assign imm_o     = imm_q;
    assign wd_o      = wd_q;
    assign wreg_o    = wreg_q;
    assign pc_o      = pc_q;
    assign illegal_o = illegal_q;
    assign mext_o    = mext_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed and randomized checks of id_stage_pipe
// against a mnemonic-level decode reference model.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, id_ready;
    logic [31:0] inst_i, pc_i;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_fwd_we, ex_is_load, mem_fwd_we, flush;
    logic [4:0]  ex_fwd_wd, mem_fwd_wd;
    logic [31:0] ex_fwd_data, mem_fwd_data;
    logic        ex_valid, ex_ready;
    logic [6:0]  aluop_o;
    logic [2:0]  alufun_o;
    logic        alufun7_o, wreg_o, illegal_o, mext_o;
    logic [31:0] reg1_o, reg2_o, imm_o, pc_o;
    logic [4:0]  wd_o;

    logic [31:0] rf [32];

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .id_ready(id_ready),
        .inst_i(inst_i), .pc_i(pc_i),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_wd(ex_fwd_wd), .ex_fwd_data(ex_fwd_data),
        .ex_is_load(ex_is_load),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_wd(mem_fwd_wd), .mem_fwd_data(mem_fwd_data),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .aluop_o(aluop_o), .alufun_o(alufun_o), .alufun7_o(alufun7_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .imm_o(imm_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o),
        .illegal_o(illegal_o), .mext_o(mext_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic        ill, mx, u1, u2, wreg, f7b;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  wd;
        logic [31:0] imm, pc, r1, r2;
    } exp_t;

    // Architectural register value as the stage should see it now.
    function automatic logic [31:0] see(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (ex_fwd_we && ex_fwd_wd == a) return ex_fwd_data;
        if (mem_fwd_we && mem_fwd_wd == a) return mem_fwd_data;
        return rf[a];
    endfunction

    function automatic exp_t model(input logic [31:0] in, input logic [31:0] pc);
        exp_t e;
        int sx, hi, v;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit isR, isI, isS, isB, isU, isJ, mx;
        op = in[6:0]; f7 = in[31:25]; f3 = in[14:12];
        isR = 0; isI = 0; isS = 0; isB = 0; isU = 0; isJ = 0; mx = 0;
        sx = int'(in);
        hi = sx >>> 31;
        case (op)
            7'h33: begin
                if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) isR = 1;
`ifdef ID_RV32M_EN
                else if (f7 == 7'h01) begin isR = 1; mx = 1; end
`endif
            end
            7'h13: isI = (f3 == 1) ? (f7 == 0) :
                         (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
            7'h03: isI = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            7'h67: isI = (f3 == 0);
            7'h23: isS = (f3 < 3);
            7'h63: isB = !(f3 inside {3'd2, 3'd3});
            7'h37, 7'h17: isU = 1;
            7'h6F: isJ = 1;
            default: ;
        endcase
        v = 0;
        if (isI) v = sx >>> 20;
        if (isS) v = (sx >>> 25) * 32 + int'(in[11:7]);
        if (isB) v = hi * 4096 + int'(in[7]) * 2048 + int'(in[30:25]) * 32 + int'(in[11:8]) * 2;
        if (isU) v = int'(in & 32'hFFFF_F000);
        if (isJ) v = hi * 1048576 + int'(in[19:12]) * 4096 + int'(in[20]) * 2048 + int'(in[30:21]) * 2;
        e.ill  = !(isR || isI || isS || isB || isU || isJ);
        e.mx   = mx;
        e.u1   = isR || isI || isS || isB;
        e.u2   = isR || isS || isB;
        e.wd   = (isR || isI || isU || isJ) ? in[11:7] : 5'd0;
        e.wreg = (e.wd != 0);
        e.f7b  = mx ? 1'b0 : in[30];
        e.op   = op;
        e.f3   = f3;
        e.imm  = v;
        e.pc   = pc;
        e.r1   = e.u1 ? see(in[19:15]) : 32'd0;
        e.r2   = e.u2 ? see(in[24:20]) : 32'd0;
        return e;
    endfunction

    function automatic logic [31:0] gen();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] i12;
        logic [19:0] u20;
        logic [31:0] r;
        logic [2:0]  ld [5];
        logic [2:0]  br [6];
        ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        br = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        rd = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3 = 3'($urandom);
        i12 = 12'($urandom);
        u20 = 20'($urandom);
        r = $urandom;
        case ($urandom_range(0, 10))
            0: begin
                f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            1: begin
                if (f3 == 1) i12[11:5] = 7'h00;
                if (f3 == 5) i12[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return {i12, rs1, f3, rd, 7'h13};
            end
            2: return {i12, rs1, ld[$urandom_range(0, 4)], rd, 7'h03};
            3: return {i12[11:5], rs2, rs1, 3'($urandom_range(0, 2)), i12[4:0], 7'h23};
            4: return {i12[11:5], rs2, rs1, br[$urandom_range(0, 5)], i12[4:0], 7'h63};
            5: return {u20, rd, 7'h37};
            6: return {u20, rd, 7'h17};
            7: return {u20, rd, 7'h6F};
            8: return {i12, rs1, 3'd0, rd, 7'h67};
            9: return {i12[11:5], rs2, rs1, 3'($urandom_range(2, 3)), i12[4:0], 7'h63};
            default: return {r[31:7], 7'h00};
        endcase
    endfunction

    task automatic chk_pl(input string t, input exp_t e);
        chk({t, ".aluop"}, 64'(aluop_o), 64'(e.op));
        chk({t, ".alufun"}, 64'(alufun_o), 64'(e.f3));
        chk({t, ".alufun7"}, 64'(alufun7_o), 64'(e.f7b));
        chk({t, ".reg1"}, 64'(reg1_o), 64'(e.r1));
        chk({t, ".reg2"}, 64'(reg2_o), 64'(e.r2));
        chk({t, ".imm"}, 64'(imm_o), 64'(e.imm));
        chk({t, ".wd"}, 64'(wd_o), 64'(e.wd));
        chk({t, ".wreg"}, 64'(wreg_o), 64'(e.wreg));
        chk({t, ".pc"}, 64'(pc_o), 64'(e.pc));
        chk({t, ".illegal"}, 64'(illegal_o), 64'(e.ill));
        chk({t, ".mext"}, 64'(mext_o), 64'(e.mx));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    exp_t        e, m_e;
    bit          m_valid, pend, m_haz, exp_rdy, acc;
    logic [31:0] cur_inst, cur_pc, pc_ctr;

    initial begin
        rst = 1'b1;
        if_valid = 1'b1; inst_i = 32'h0050_0093; pc_i = 32'h100;
        ex_fwd_we = 0; ex_fwd_wd = 0; ex_fwd_data = 0; ex_is_load = 0;
        mem_fwd_we = 0; mem_fwd_wd = 0; mem_fwd_data = 0;
        flush = 0; ex_ready = 1;
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        #1 rst = 1'b0;
        #7;
        chk("rst.id_ready", 64'(id_ready), 64'(0));
        chk("rst.ex_valid", 64'(ex_valid), 64'(0));
        chk("rst.imm", 64'(imm_o), 64'(0));
        chk("rst.wd", 64'(wd_o), 64'(0));
        chk("rst.pc", 64'(pc_o), 64'(0));
        chk("rst.illegal", 64'(illegal_o), 64'(0));
        #4 rst = 1'b1;
        tick();

        // ADDI x1,x0,5
        inst_i = 32'h0050_0093; pc_i = 32'h100; if_valid = 1; ex_ready = 1;
        #1 chk("addi.id_ready", 64'(id_ready), 64'(1));
        tick();
        chk("addi.ex_valid", 64'(ex_valid), 64'(1));
        chk("addi.imm", 64'(imm_o), 64'(5));
        chk("addi.wd", 64'(wd_o), 64'(1));
        chk("addi.wreg", 64'(wreg_o), 64'(1));
        chk("addi.reg1", 64'(reg1_o), 64'(0));
        chk("addi.pc", 64'(pc_o), 64'(32'h100));

        // ADD x3,x1,x2 with EX fwd x1 and MEM fwd x2
        inst_i = 32'h0020_81B3; pc_i = 32'h104;
        ex_fwd_we = 1; ex_fwd_wd = 1; ex_fwd_data = 7;
        mem_fwd_we = 1; mem_fwd_wd = 2; mem_fwd_data = 9;
        tick();
        chk("fwd.reg1", 64'(reg1_o), 64'(7));
        chk("fwd.reg2", 64'(reg2_o), 64'(9));
        chk("fwd.wd", 64'(wd_o), 64'(3));

        // Load-use: LW x5 in EX, ADD x6,x5,x5 in ID
        inst_i = 32'h0052_8333; pc_i = 32'h108;
        ex_is_load = 1; ex_fwd_we = 1; ex_fwd_wd = 5; ex_fwd_data = 32'hDEAD;
        mem_fwd_we = 0;
        #1 chk("lu.id_ready", 64'(id_ready), 64'(0));
        tick();
        chk("lu.bubble", 64'(ex_valid), 64'(0));
        ex_is_load = 0; ex_fwd_we = 0;
        mem_fwd_we = 1; mem_fwd_wd = 5; mem_fwd_data = 32'h1234;
        #1 chk("lu.retry_ready", 64'(id_ready), 64'(1));
        tick();
        chk("lu.ex_valid", 64'(ex_valid), 64'(1));
        chk("lu.reg1", 64'(reg1_o), 64'(32'h1234));
        chk("lu.reg2", 64'(reg2_o), 64'(32'h1234));
        chk("lu.wd", 64'(wd_o), 64'(6));

        // Backpressure: ex_ready=0 for 3 cycles
        inst_i = 32'h0030_0393; pc_i = 32'h10C; mem_fwd_we = 0; ex_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold.id_ready", 64'(id_ready), 64'(0));
            tick();
            chk("hold.ex_valid", 64'(ex_valid), 64'(1));
            chk("hold.wd", 64'(wd_o), 64'(6));
            chk("hold.reg1", 64'(reg1_o), 64'(32'h1234));
        end
        ex_ready = 1;
        #1 chk("hold.release", 64'(id_ready), 64'(1));
        tick();
        chk("hold.next_wd", 64'(wd_o), 64'(7));
        chk("hold.next_imm", 64'(imm_o), 64'(3));
        if_valid = 0;
        tick();
        chk("hold.no_dup", 64'(ex_valid), 64'(0));

        // Flush while in the load-use stall cycle
        inst_i = 32'h0052_8333; pc_i = 32'h110; if_valid = 1;
        ex_is_load = 1; ex_fwd_we = 1; ex_fwd_wd = 5;
        tick();
        flush = 1; ex_is_load = 0; ex_fwd_we = 0;
        tick();
        chk("flush.ex_valid", 64'(ex_valid), 64'(0));
        flush = 0; if_valid = 0;
        #1 chk("flush.id_ready", 64'(id_ready), 64'(1));
        tick();

        // MUL x1,x2,x3
        inst_i = 32'h0231_00B3; pc_i = 32'h114; if_valid = 1;
        tick();
        chk("mul.ex_valid", 64'(ex_valid), 64'(1));
`ifdef ID_RV32M_EN
        chk("mul.illegal", 64'(illegal_o), 64'(0));
        chk("mul.mext", 64'(mext_o), 64'(1));
        chk("mul.wreg", 64'(wreg_o), 64'(1));
        chk("mul.alufun7", 64'(alufun7_o), 64'(0));
`else
        chk("mul.illegal", 64'(illegal_o), 64'(1));
        chk("mul.mext", 64'(mext_o), 64'(0));
        chk("mul.wreg", 64'(wreg_o), 64'(0));
`endif

        // Async reset while stalled with a valid op held
        inst_i = 32'h0050_0093; pc_i = 32'h118;
        tick();
        inst_i = 32'h0052_8333; ex_ready = 0;
        ex_is_load = 1; ex_fwd_we = 1; ex_fwd_wd = 5;
        #1 chk("rstm.id_ready", 64'(id_ready), 64'(0));
        #2 rst = 0;
        #1;
        chk("rstm.ex_valid", 64'(ex_valid), 64'(0));
        chk("rstm.id_ready_low", 64'(id_ready), 64'(0));
        chk("rstm.wd", 64'(wd_o), 64'(0));
        rst = 1; ex_is_load = 0; ex_fwd_we = 0; if_valid = 0; ex_ready = 1;
        #1 chk("rstm.recover", 64'(id_ready), 64'(1));
        tick();

        // Randomized traffic against the reference model
        m_valid = 0; pend = 0; pc_ctr = 32'h1000;
        cur_inst = 0; cur_pc = 0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                cur_inst = gen(); cur_pc = pc_ctr; pc_ctr += 4;
            end
            if_valid = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
            inst_i = cur_inst; pc_i = cur_pc;
            ex_ready = ($urandom_range(0, 3) != 0);
            ex_fwd_we = 1'($urandom_range(0, 1));
            ex_fwd_wd = 5'($urandom_range(0, 7));
            ex_fwd_data = $urandom;
            ex_is_load = ($urandom_range(0, 3) == 0);
            mem_fwd_we = 1'($urandom_range(0, 1));
            mem_fwd_wd = 5'($urandom_range(0, 7));
            mem_fwd_data = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            for (int r = 0; r < 32; r++) rf[r] = $urandom;
            #1;
            e = model(inst_i, pc_i);
            m_haz = if_valid && ex_is_load && ex_fwd_we && ex_fwd_wd != 0 &&
                    ((e.u1 && inst_i[19:15] == ex_fwd_wd) ||
                     (e.u2 && inst_i[24:20] == ex_fwd_wd));
            exp_rdy = (!m_valid || ex_ready) && !m_haz;
            chk("rnd.id_ready", 64'(id_ready), 64'(exp_rdy));
            acc = if_valid && exp_rdy;
            if (flush) m_valid = 0;
            else if (acc) begin m_valid = 1; m_e = e; end
            else if (!m_valid || ex_ready) m_valid = 0;
            pend = if_valid && !acc && !flush;
            tick();
            chk("rnd.ex_valid", 64'(ex_valid), 64'(m_valid));
            if (m_valid) chk_pl("rnd", m_e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
